// File: rtl/mul_div_unit.sv
// Purpose : execute-stage multiply/divide unit owning the architectural HI/LO registers.
// Latency : mult/multu (madd/msub) busy MULT_CYCLES, div/divu busy DIV_CYCLES; mfhi/mflo combinational, mthi/mtlo next cycle.
// Backpressure: no internal queueing; BusyE tells the hazard unit to stall, and ops arriving while busy are dropped.
//
// Ports:
//   clk, reset_n      : clock and asynchronous active-low reset
//   MDUOpE, OpValidE  : op code from decode (0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo,9 madd,10 msub)
//   SrcAE, SrcBE      : forwarded rs / rt operands
//   StartE            : a long op is being accepted this cycle (combinational)
//   BusyE             : long op in flight (registered)
//   HI, LO            : architectural result registers
//   MDUOutE           : mfhi/mflo read data (combinational), zero otherwise
//
// Optional feature: define MDU_MADD_EN to add madd (9) / msub (10) accumulating into {HI,LO}.
// Without it, codes 9 and 10 decode as none and no accumulator datapath exists.

module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  MDUOpE,
    input  logic        OpValidE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    output logic        StartE,
    output logic        BusyE,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOutE
);

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;
`endif

    // The counter is loaded with N-1 so that the commit edge lands exactly N
    // cycles after the start edge.
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] pendHi;
    logic [31:0] pendLo;
    logic        pendCommit;

    // ------------------------------------------------------------------
    // Op decode: an invalid slot is a bubble regardless of the code.
    // ------------------------------------------------------------------
    logic [3:0] opEff;
    logic       isMul;
    logic       isDiv;
    logic       isAcc;
    logic       isLongOp;

    always_comb begin
        opEff = OP_NONE;
        if (OpValidE) begin
            opEff = MDUOpE;
        end
    end

    assign isMul = (opEff == OP_MULT) || (opEff == OP_MULTU);
    assign isDiv = (opEff == OP_DIV)  || (opEff == OP_DIVU);
`ifdef MDU_MADD_EN
    assign isAcc = (opEff == OP_MADD) || (opEff == OP_MSUB);
`else
    assign isAcc = 1'b0;
`endif
    assign isLongOp = isMul || isDiv || isAcc;

    assign StartE = isLongOp && !BusyE;

    // ------------------------------------------------------------------
    // Multiplier: explicit 64-bit extension so the low 64 bits of the
    // product are exact for both signednesses.
    // ------------------------------------------------------------------
    logic signed [63:0] prodS;
    logic        [63:0] prodU;

    assign prodS = $signed({{32{SrcAE[31]}}, SrcAE}) * $signed({{32{SrcBE[31]}}, SrcBE});
    assign prodU = {32'd0, SrcAE} * {32'd0, SrcBE};

`ifdef MDU_MADD_EN
    // Accumulator base is whatever HI/LO hold at the start edge; wraps mod 2^64.
    logic [63:0] accSum;
    logic [63:0] accDiff;

    assign accSum  = {HI, LO} + prodS;
    assign accDiff = {HI, LO} - prodS;
`endif

    // ------------------------------------------------------------------
    // Divider: one unsigned divider shared by div and divu. Signed division
    // works on magnitudes and re-applies signs, which gives truncation toward
    // zero and a remainder carrying the dividend's sign. 0x80000000 / -1 falls
    // out naturally: |a| = 0x80000000, |b| = 1, negated quotient wraps back to
    // 0x80000000 with remainder 0.
    // ------------------------------------------------------------------
    logic        signedDiv;
    logic        divByZero;
    logic [31:0] absA;
    logic [31:0] absB;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] uQuo;
    logic [31:0] uRem;
    logic [31:0] divQuo;
    logic [31:0] divRem;

    assign signedDiv = (opEff == OP_DIV);
    assign divByZero = (SrcBE == 32'd0);
    assign absA      = SrcAE[31] ? (~SrcAE + 32'd1) : SrcAE;
    assign absB      = SrcBE[31] ? (~SrcBE + 32'd1) : SrcBE;
    assign dividend  = signedDiv ? absA : SrcAE;
    // A zero divisor is replaced to keep the datapath X-free; the result is
    // never committed in that case.
    assign divisor   = divByZero ? 32'd1 : (signedDiv ? absB : SrcBE);
    assign uQuo      = dividend / divisor;
    assign uRem      = dividend % divisor;

    always_comb begin
        divQuo = uQuo;
        divRem = uRem;
        if (signedDiv) begin
            if (SrcAE[31] ^ SrcBE[31]) begin
                divQuo = ~uQuo + 32'd1;
            end
            if (SrcAE[31]) begin
                divRem = ~uRem + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result select for the pending registers.
    // ------------------------------------------------------------------
    logic [31:0] resHi;
    logic [31:0] resLo;
    logic        resCommit;

    always_comb begin
        resHi     = prodS[63:32];
        resLo     = prodS[31:0];
        resCommit = 1'b1;
        case (opEff)
            OP_MULT: begin
                resHi = prodS[63:32];
                resLo = prodS[31:0];
            end
            OP_MULTU: begin
                resHi = prodU[63:32];
                resLo = prodU[31:0];
            end
            OP_DIV, OP_DIVU: begin
                resHi     = divRem;
                resLo     = divQuo;
                resCommit = !divByZero;
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                resHi = accSum[63:32];
                resLo = accSum[31:0];
            end
            OP_MSUB: begin
                resHi = accDiff[63:32];
                resLo = accDiff[31:0];
            end
`endif
            default: begin
                resHi = prodS[63:32];
                resLo = prodS[31:0];
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM and architectural state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            BusyE      <= 1'b0;
            HI         <= 32'd0;
            LO         <= 32'd0;
            pendHi     <= 32'd0;
            pendLo     <= 32'd0;
            pendCommit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (StartE) begin
                        pendHi     <= resHi;
                        pendLo     <= resLo;
                        pendCommit <= resCommit;
                        cnt        <= isDiv ? DIV_LOAD : MULT_LOAD;
                        BusyE      <= 1'b1;
                        state      <= RUN;
                    end else begin
                        if (opEff == OP_MTHI) begin
                            HI <= SrcAE;
                        end
                        if (opEff == OP_MTLO) begin
                            LO <= SrcAE;
                        end
                    end
                end
                RUN: begin
                    // Every incoming op is ignored here; the hazard unit holds it.
                    if (cnt == 4'd0) begin
                        if (pendCommit) begin
                            HI <= pendHi;
                            LO <= pendLo;
                        end
                        BusyE <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    BusyE <= 1'b0;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Move-from read port: reads the committed registers, so a read while
    // busy returns the pre-operation value.
    // ------------------------------------------------------------------
    always_comb begin
        MDUOutE = 32'd0;
        case (opEff)
            OP_MFHI: MDUOutE = HI;
            OP_MFLO: MDUOutE = LO;
            default: MDUOutE = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Purpose : directed self-checking bench for mul_div_unit.
// Latency : checks busy windows of MULT_CYCLES / DIV_CYCLES and HI/LO visibility after commit.
// Backpressure: exercises ops issued while busy, which must be dropped.

module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  MDUOpE;
    logic        OpValidE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        StartE;
    logic        BusyE;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOutE;

    int checks   = 0;
    int failures = 0;

    mul_div_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .MDUOpE  (MDUOpE),
        .OpValidE(OpValidE),
        .SrcAE   (SrcAE),
        .SrcBE   (SrcBE),
        .StartE  (StartE),
        .BusyE   (BusyE),
        .HI      (HI),
        .LO      (LO),
        .MDUOutE (MDUOutE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        MDUOpE   = op;
        OpValidE = 1'b1;
        SrcAE    = a;
        SrcBE    = b;
        #1;
    endtask

    task automatic idleIn();
        MDUOpE   = 4'd0;
        OpValidE = 1'b0;
        SrcAE    = 32'd0;
        SrcBE    = 32'd0;
        #1;
    endtask

    // Counts cycles with BusyE high, starting from the current sample; bounded.
    task automatic countBusy(output int n);
        n = 0;
        while (BusyE && n < 40) begin
            n++;
            tick();
        end
    endtask

    // Issue a long op, verify it is accepted and that it stays busy for expCycles.
    task automatic runLong(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int expCycles);
        int n;
        drive(op, a, b);
        check({tag, "_start"}, 32'(StartE), 32'd1);
        tick();
        idleIn();
        countBusy(n);
        check({tag, "_busy_cycles"}, 32'(n), 32'(expCycles));
    endtask

    initial begin
        int n;
        reset_n  = 1'b0;
        MDUOpE   = 4'd0;
        OpValidE = 1'b0;
        SrcAE    = 32'd0;
        SrcBE    = 32'd0;
        #12;
        check("rst_busy", 32'(BusyE), 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_start", 32'(StartE), 32'd0);
        check("rst_out", MDUOutE, 32'd0);
        reset_n = 1'b1;
        tick();

        // Signed multiply: -1 * 2 = -2
        runLong("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 5);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFE);
        drive(4'd5, 32'd0, 32'd0);
        check("mult_mfhi_first_idle", MDUOutE, 32'hFFFF_FFFF);
        idleIn();

        // Unsigned multiply: 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
        runLong("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5);
        check("multu_hi", HI, 32'h0000_0001);
        check("multu_lo", LO, 32'hFFFF_FFFE);

        // Signed divide: -7 / 2 = -3 rem -1
        runLong("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        // Overflow corner
        runLong("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        check("div_ovf_lo", LO, 32'h8000_0000);
        check("div_ovf_hi", HI, 32'h0000_0000);

        // Unsigned divide sanity: 100 / 7 = 14 rem 2
        runLong("divu", 4'd4, 32'd100, 32'd7, 10);
        check("divu_lo", LO, 32'd14);
        check("divu_hi", HI, 32'd2);

        // mthi / mtlo, then divide by zero leaves them untouched
        drive(4'd7, 32'h0000_1234, 32'd0);
        tick();
        check("mthi", HI, 32'h0000_1234);
        drive(4'd8, 32'd0, 32'd0);
        tick();
        check("mtlo", LO, 32'd0);
        runLong("divu_zero", 4'd4, 32'd5, 32'd0, 10);
        check("divu_zero_hi", HI, 32'h0000_1234);
        check("divu_zero_lo", LO, 32'd0);

        // Invalid slot and reserved code have no effect
        MDUOpE   = 4'd7;
        OpValidE = 1'b0;
        SrcAE    = 32'h5555_5555;
        #1;
        tick();
        check("mthi_invalid", HI, 32'h0000_1234);
        drive(4'd12, 32'd3, 32'd3);
        check("code12_start", 32'(StartE), 32'd0);
        check("code12_out", MDUOutE, 32'd0);
        tick();
        check("code12_busy", 32'(BusyE), 32'd0);
        idleIn();

        // mflo while busy, and a mult issued while busy
        drive(4'd1, 32'd6, 32'd7);
        tick();                       // start edge; busy cycle 1
        idleIn();
        tick();                       // busy cycle 2
        drive(4'd6, 32'd0, 32'd0);
        check("mflo_busy_old", MDUOutE, 32'd0);
        drive(4'd1, 32'd2, 32'd2);
        check("mult_busy_start", 32'(StartE), 32'd0);
        tick();                       // busy cycle 3
        idleIn();
        countBusy(n);
        check("mult_busy_no_restart", 32'(n), 32'd3);
        check("mult_busy_lo", LO, 32'd42);
        check("mult_busy_hi", HI, 32'd0);

        // Accumulate: HI=0, LO=0xFFFFFFFF, then madd 1*1
        drive(4'd7, 32'd0, 32'd0);
        tick();
        drive(4'd8, 32'hFFFF_FFFF, 32'd0);
        tick();
`ifdef MDU_MADD_EN
        runLong("madd", 4'd9, 32'd1, 32'd1, 5);
        check("madd_hi", HI, 32'd1);
        check("madd_lo", LO, 32'd0);
        runLong("msub", 4'd10, 32'd1, 32'd1, 5);
        check("msub_hi", HI, 32'd0);
        check("msub_lo", LO, 32'hFFFF_FFFF);
`else
        drive(4'd9, 32'd1, 32'd1);
        check("madd_off_start", 32'(StartE), 32'd0);
        tick();
        idleIn();
        check("madd_off_busy", 32'(BusyE), 32'd0);
        check("madd_off_hi", HI, 32'd0);
        check("madd_off_lo", LO, 32'hFFFF_FFFF);
`endif

        // Reset in the middle of a multiply
        drive(4'd1, 32'hFFFF_FFFF, 32'd2);
        tick();                       // busy cycle 1
        idleIn();
        tick();                       // busy cycle 2
        tick();                       // busy cycle 3
        check("mid_rst_busy_before", 32'(BusyE), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(BusyE), 32'd0);
        check("mid_rst_hi", HI, 32'd0);
        check("mid_rst_lo", LO, 32'd0);
        #1;
        reset_n = 1'b1;
        repeat (8) tick();
        check("mid_rst_no_commit_hi", HI, 32'd0);
        check("mid_rst_no_commit_lo", LO, 32'd0);
        check("mid_rst_idle", 32'(BusyE), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
